// File: rtl/multi_counter_ctrl.sv
// Multi-channel step counter controller: per-channel one-shot/auto-reload counters loaded through
// a shared config port, with sticky overflow and a round-robin finish-event port.
//   state   | meaning
//   ST_IDLE | never configured since reset; steps flag overflow, recounts ignored
//   ST_RUN  | counting steps toward the target
//   ST_DONE | one-shot target reached; steps flag overflow, recount or config re-arms
module multi_counter_ctrl #(
    parameter int COUNTER_BITWIDTH = 8,
    parameter int NUM_CH           = 4,
    parameter int CH_IDX_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               en_i,
    input  logic                               config_valid_i,
    output logic                               config_ready_o,
    input  logic [CH_IDX_W-1:0]                config_ch_i,
    input  logic [COUNTER_BITWIDTH-1:0]        config_target_i,
    input  logic                               config_mode_i,
    input  logic [NUM_CH-1:0]                  recount_en_i,
    input  logic [NUM_CH-1:0]                  step_en_i,
    output logic [NUM_CH*COUNTER_BITWIDTH-1:0] count_o,
    output logic [NUM_CH-1:0]                  busy_o,
    output logic                               finish_valid_o,
    output logic [CH_IDX_W-1:0]                finish_ch_o,
    input  logic                               finish_ready_i,
    output logic [NUM_CH-1:0]                  overflow_o,
    input  logic [NUM_CH-1:0]                  clear_overflow_i
);

    localparam int W = COUNTER_BITWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q  [NUM_CH];
    state_t              state_d  [NUM_CH];
    logic [W-1:0]        count_q  [NUM_CH];
    logic [W-1:0]        count_d  [NUM_CH];
    logic [W-1:0]        target_q [NUM_CH];
    logic [W-1:0]        target_d [NUM_CH];
    logic [NUM_CH-1:0]   mode_q, mode_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [NUM_CH-1:0]   ovf_q, ovf_d;
    logic [NUM_CH-1:0]   busy_q, busy_d;
    logic [CH_IDX_W-1:0] rr_q, rr_d;

    logic                ch_running;
    logic                cfg_acc;
    logic [NUM_CH-1:0]   cfg_hit;
    logic [NUM_CH-1:0]   pop_hit;
    logic                pop;
    logic [CH_IDX_W-1:0] fin_ch;
    int                  idx;
    logic                evt;
    logic                ovf_set;
    logic [W-1:0]        tgt_m1;

    // An out-of-range config_ch_i matches no channel: ready stays high and the request is dropped.
    always_comb begin
        ch_running = 1'b0;
        cfg_hit    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (config_ch_i == CH_IDX_W'(c)) begin
                ch_running = (state_q[c] == ST_RUN);
                cfg_hit[c] = 1'b1;
            end
        end
    end

    assign config_ready_o = en_i && !ch_running;
    assign cfg_acc        = config_valid_i && config_ready_o;

    // Scan from the far end so the first pending channel at or after the pointer wins.
    always_comb begin
        fin_ch = '0;
        idx    = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (pend_q[idx[CH_IDX_W-1:0]]) fin_ch = idx[CH_IDX_W-1:0];
        end
    end

    assign finish_valid_o = |pend_q;
    assign finish_ch_o    = fin_ch;
    assign pop            = finish_valid_o && finish_ready_i;

    always_comb begin
        pop_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pop_hit[c] = pop && (fin_ch == CH_IDX_W'(c));
        end
    end

    always_comb begin
        mode_d  = mode_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        evt     = 1'b0;
        ovf_set = 1'b0;
        tgt_m1  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]  = state_q[c];
            count_d[c]  = count_q[c];
            target_d[c] = target_q[c];
            evt         = 1'b0;
            ovf_set     = 1'b0;
            tgt_m1      = target_q[c] - W'(1);

            if (cfg_acc && cfg_hit[c]) begin
                target_d[c] = config_target_i;
                mode_d[c]   = config_mode_i;
                count_d[c]  = '0;
                state_d[c]  = ST_RUN;
            end else if (en_i && recount_en_i[c] && (state_q[c] != ST_IDLE)) begin
                count_d[c] = '0;
                state_d[c] = ST_RUN;
            end else if (en_i && step_en_i[c]) begin
                if (state_q[c] == ST_RUN) begin
                    // target 0 wraps tgt_m1 to all-ones, giving the full 2^W step range
                    if (count_q[c] == tgt_m1) begin
                        count_d[c] = '0;
                        evt        = 1'b1;
                        if (!mode_q[c]) state_d[c] = ST_DONE;
                    end else begin
                        count_d[c] = count_q[c] + W'(1);
                    end
                end else begin
                    ovf_set = 1'b1;
                end
            end

            if (evt && pend_q[c] && !pop_hit[c]) ovf_set = 1'b1;
            pend_d[c] = evt || (pend_q[c] && !pop_hit[c]);
            ovf_d[c]  = ovf_set || (ovf_q[c] && !clear_overflow_i[c]);
            busy_d[c] = (state_d[c] == ST_RUN);
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (pop) begin
            rr_d = (fin_ch == CH_IDX_W'(NUM_CH - 1)) ? '0 : fin_ch + CH_IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= ST_IDLE;
                count_q[c]  <= '0;
                target_q[c] <= '0;
            end
            mode_q <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
            busy_q <= '0;
            rr_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= state_d[c];
                count_q[c]  <= count_d[c];
                target_q[c] <= target_d[c];
            end
            mode_q <= mode_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            busy_q <= busy_d;
            rr_q   <= rr_d;
        end
    end

    always_comb begin
        count_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            count_o[c*W +: W] = count_q[c];
        end
    end

    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_multi_counter_ctrl.sv
// Bench for multi_counter_ctrl: directed scenarios with literal expectations, then random
// stimulus, all compared every cycle against a behavioural channel model.
module tb_multi_counter_ctrl;
    localparam int W   = 8;
    localparam int NCH = 4;
    localparam int CW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, en, cfg_valid, cfg_ready, cfg_mode, fin_valid, fin_ready;
    logic [CW-1:0]     cfg_ch, fin_ch;
    logic [W-1:0]      cfg_target;
    logic [NCH-1:0]    recount, step, busy, ovf, clr;
    logic [NCH*W-1:0]  count;

    multi_counter_ctrl #(.COUNTER_BITWIDTH(W), .NUM_CH(NCH)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .config_valid_i(cfg_valid), .config_ready_o(cfg_ready), .config_ch_i(cfg_ch),
        .config_target_i(cfg_target), .config_mode_i(cfg_mode),
        .recount_en_i(recount), .step_en_i(step),
        .count_o(count), .busy_o(busy),
        .finish_valid_o(fin_valid), .finish_ch_o(fin_ch), .finish_ready_i(fin_ready),
        .overflow_o(ovf), .clear_overflow_i(clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: steps taken so far, steps needed, whether configured/running, event queue flags.
    int m_cnt     [NCH];
    int m_tgt     [NCH];
    bit m_mode    [NCH];
    bit m_running [NCH];
    bit m_armed   [NCH];
    bit m_pend    [NCH];
    bit m_ovf     [NCH];
    int m_rr;
    bit m_init = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_fv();
        for (int c = 0; c < NCH; c++) if (m_pend[c]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_fch();
        for (int k = 0; k < NCH; k++) if (m_pend[(m_rr + k) % NCH]) return (m_rr + k) % NCH;
        return 0;
    endfunction

    function automatic bit m_ready();
        return en && !m_running[int'(cfg_ch)];
    endfunction

    function automatic logic [NCH*W-1:0] m_count_vec();
        logic [NCH*W-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c*W +: W] = m_cnt[c][W-1:0];
        return v;
    endfunction

    function automatic logic [NCH-1:0] m_bits(input bit b [NCH]);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = b[c];
        return v;
    endfunction

    task automatic model_step();
        bit pop, acc, ev, os, popped;
        int pch, need;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 0; m_tgt[c] = 0; m_mode[c] = 0; m_running[c] = 0;
                m_armed[c] = 0; m_pend[c] = 0; m_ovf[c] = 0;
            end
            m_rr   = 0;
            m_init = 1;
            return;
        end
        pop = m_fv() && fin_ready;
        pch = m_fch();
        acc = cfg_valid && m_ready();
        for (int c = 0; c < NCH; c++) begin
            ev = 0; os = 0;
            popped = pop && (pch == c);
            if (acc && int'(cfg_ch) == c) begin
                m_tgt[c] = int'(cfg_target); m_mode[c] = cfg_mode; m_cnt[c] = 0;
                m_running[c] = 1; m_armed[c] = 1;
            end else if (en && recount[c] && m_armed[c]) begin
                m_cnt[c] = 0; m_running[c] = 1;
            end else if (en && step[c]) begin
                if (m_running[c]) begin
                    need = (m_tgt[c] == 0) ? (1 << W) : m_tgt[c];
                    if (m_cnt[c] + 1 == need) begin
                        m_cnt[c] = 0; ev = 1;
                        if (!m_mode[c]) m_running[c] = 0;
                    end else begin
                        m_cnt[c] = m_cnt[c] + 1;
                    end
                end else begin
                    os = 1;
                end
            end
            if (ev && m_pend[c] && !popped) os = 1;
            if (ev) m_pend[c] = 1;
            else if (popped) m_pend[c] = 0;
            if (os) m_ovf[c] = 1;
            else if (clr[c]) m_ovf[c] = 0;
        end
        if (pop) m_rr = (pch + 1) % NCH;
    endtask

    // Inputs are driven at the falling edge; outputs are compared just after, before the rising edge.
    task automatic cycle();
        #1;
        if (m_init) begin
            chk("count_o", count, m_count_vec());
            chk("busy_o", busy, m_bits(m_running));
            chk("overflow_o", ovf, m_bits(m_ovf));
            chk("finish_valid_o", fin_valid, m_fv());
            chk("config_ready_o", cfg_ready, m_ready());
            if (m_fv()) chk("finish_ch_o", fin_ch, m_fch());
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        rst = 0; en = 1; cfg_valid = 0; cfg_ch = '0; cfg_target = '0; cfg_mode = 0;
        recount = '0; step = '0; fin_ready = 0; clr = '0;
    endtask

    task automatic configure(input int ch, input int tgt, input bit mode);
        cfg_valid = 1; cfg_ch = CW'(ch); cfg_target = W'(tgt); cfg_mode = mode;
        cycle();
        cfg_valid = 0;
    endtask

    task automatic pop_expect(input int ch, input string name);
        fin_ready = 1;
        #1;
        chk({name, "_valid"}, fin_valid, 1);
        chk({name, "_ch"}, fin_ch, ch);
        cycle();
        fin_ready = 0;
    endtask

    initial begin
        idle_in();
        @(negedge clk);
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_fvalid", fin_valid, 0);
        chk("rst_fch", fin_ch, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ready", cfg_ready, 1);

        // one-shot ch1, target 3
        configure(1, 3, 0);
        chk("os_busy", busy[1], 1);
        step = 4'b0010;
        cycle(); chk("os_cnt1", count[15:8], 1);
        cycle(); chk("os_cnt2", count[15:8], 2);
        chk("os_nofin", fin_valid, 0);
        cycle(); chk("os_cnt0", count[15:8], 0);
        chk("os_fvalid", fin_valid, 1);
        chk("os_fch", fin_ch, 1);
        chk("os_busy_done", busy[1], 0);
        cycle(); chk("os_ovf", ovf[1], 1);
        step = '0;
        pop_expect(1, "os_pop");
        chk("os_drained", fin_valid, 0);
        clr = 4'b0010; cycle(); clr = '0;
        chk("os_clr", ovf[1], 0);

        // auto-reload ch0, target 2, consumer stalled
        configure(0, 2, 1);
        step = 4'b0001;
        repeat (4) cycle();
        step = '0;
        chk("ar_ovf", ovf[0], 1);
        chk("ar_busy", busy[0], 1);
        chk("ar_fch", fin_ch, 0);
        chk("ar_cnt", count[7:0], 0);
        pop_expect(0, "ar_pop");
        clr = 4'b0001; cycle(); clr = '0;

        // full-range ch2, target 0 means 256 steps
        configure(2, 0, 0);
        step = 4'b0100;
        repeat (255) cycle();
        chk("fr_cnt255", count[23:16], 255);
        chk("fr_nofin", fin_valid, 0);
        cycle();
        step = '0;
        chk("fr_cnt0", count[23:16], 0);
        chk("fr_fch", fin_ch, 2);
        pop_expect(2, "fr_pop");

        // round robin from a fresh pointer
        rst = 1; cycle(); rst = 0;
        configure(0, 1, 0);
        configure(3, 1, 0);
        step = 4'b1001; cycle(); step = '0;
        pop_expect(0, "rr_a0");
        pop_expect(3, "rr_a3");
        recount = 4'b1001; cycle(); recount = '0;
        step = 4'b1001; cycle(); step = '0;
        pop_expect(0, "rr_b0");
        pop_expect(3, "rr_b3");
        recount = 4'b0001; cycle(); recount = '0;
        step = 4'b0001; cycle(); step = '0;
        pop_expect(0, "rr_c0");
        recount = 4'b1001; cycle(); recount = '0;
        step = 4'b1001; cycle(); step = '0;
        pop_expect(3, "rr_d3");
        pop_expect(0, "rr_d0");

        // priority and enable
        cfg_valid = 1; cfg_ch = 2'd1; cfg_target = 8'd5; cfg_mode = 0; step = 4'b0010;
        cycle();
        cfg_valid = 0;
        chk("pri_cnt", count[15:8], 0);
        chk("pri_busy", busy[1], 1);
        chk("pri_ovf", ovf[1], 0);
        cycle(); cycle();
        chk("pri_cnt2", count[15:8], 2);
        step = '0; recount = 4'b0010; cycle(); recount = '0;
        chk("rec_cnt", count[15:8], 0);
        step = 4'b0010; cycle();
        en = 0;
        #1;
        chk("en0_ready", cfg_ready, 0);
        cycle();
        chk("en0_cnt", count[15:8], 1);
        chk("en0_ovf", ovf[1], 0);
        en = 1; step = '0;
        rst = 1; cycle(); rst = 0;
        chk("mrst_count", count, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_fvalid", fin_valid, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            en        = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CW'($urandom_range(0, NCH - 1));
            cfg_target = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 255))
                                                     : W'($urandom_range(0, 4));
            cfg_mode  = 1'($urandom_range(0, 1));
            fin_ready = ($urandom_range(0, 2) == 0);
            for (int c = 0; c < NCH; c++) begin
                recount[c] = ($urandom_range(0, 15) == 0);
                step[c]    = ($urandom_range(0, 1) == 0);
                clr[c]     = ($urandom_range(0, 7) == 0);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
